// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX scheduler: FSM state encoding and default oversample ratio.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int OVERSAMPLE_DEFAULT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
// Zero latency; when no request is set, gnt_o is all zeros and idx_o is 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);

  localparam int IW = $clog2(NUM_REQ);

  logic          found;
  logic [IW-1:0] k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = IW'((int'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin shared UART transmitter (8N1, LSB first); define UART_TX_PARITY_EN to add an even-parity bit.
// Grant is registered one cycle after an idle cycle with a request; requests wait while a frame is in flight.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          baud_tick,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy,
  output logic                          tx_done,
  output logic                          tx
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);

  uart_state_t           state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    owner_d = owner_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q == IDLE) begin
      tick_d = '0;
      if (|req) begin
        grant_d = arb_gnt;
        owner_d = arb_idx;
        shreg_d = data_arr[arb_idx];
`ifdef UART_TX_PARITY_EN
        par_d   = ^data_arr[arb_idx];
`endif
        busy_d  = 1'b1;
        tx_d    = 1'b0;
        state_d = START;
        ptr_d   = (arb_idx == IW'(NUM_REQ-1)) ? '0 : arb_idx + IW'(1);
      end
    end else if (baud_tick) begin
      if (tick_q != TW'(OVERSAMPLE-1)) begin
        tick_d = tick_q + TW'(1);
      end else begin
        // Bit boundary: tx_d carries the level of the bit that starts now.
        tick_d = '0;
        case (state_q)
          START: begin
            state_d = DATA;
            bit_d   = '0;
            tx_d    = shreg_q[0];
          end
          DATA: begin
            if (bit_q == BW'(DATA_WIDTH-1)) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
              tx_d    = par_q;
`else
              state_d = STOP;
              tx_d    = 1'b1;
`endif
            end else begin
              bit_d   = bit_q + BW'(1);
              shreg_d = shreg_q >> 1;
              tx_d    = shreg_q[1];
            end
          end
          PARITY: begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
          STOP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) par_q <= 1'b0;
    else       par_q <= par_d;
  end
`endif

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign tx_done = done_q;
  assign tx      = tx_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: frame-level reference model compared every cycle plus directed literal checks.
module tb_uart_tx_sched;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int OS = 16;
  localparam int IW = $clog2(N);

`ifdef UART_TX_PARITY_EN
  localparam int          FB        = 11;
  localparam logic [10:0] LIT_55    = 11'b10010101010;
  localparam logic [10:0] LIT_07    = 11'b11000001110;
  localparam int          LIT_TICKS = 176;
`else
  localparam int          FB        = 10;
  localparam logic [10:0] LIT_55    = 11'b01010101010;
  localparam logic [10:0] LIT_07    = 11'b01000001110;
  localparam int          LIT_TICKS = 160;
`endif

  logic            clk;
  logic            reset;
  logic            baud_tick;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    grant;
  logic [IW-1:0]   owner;
  logic            busy;
  logic            tx_done;
  logic            tx;

  uart_tx_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .reset     (reset),
    .baud_tick (baud_tick),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .owner     (owner),
    .busy      (busy),
    .tx_done   (tx_done),
    .tx        (tx)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int pend [N];
  int done_cnt = 0;
  int gq [$];
  int gcq [$];
  int dcq [$];

  // Reference model state: a frame is a bit vector indexed by elapsed ticks / OS.
  logic         m_busy = 1'b0;
  logic [N-1:0] m_grant = '0;
  logic         m_done = 1'b0;
  int           m_owner = 0;
  int           m_ptr = 0;
  int           m_ticks = 0;
  int           m_sel = 0;
  logic [7:0]   m_byte = '0;
  logic [11:0]  m_bits = '1;

  logic [N-1:0] g;
  int           t_cnt;
  int           exp_o [5];

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    return (v & (N'(1) << i)) != '0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1 baud_tick = ~baud_tick;
    end
  end

  // Requesters: hold req while frames are pending, consume one per grant.
  initial begin
    logic [N-1:0] r;
    req = '0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    forever begin
      @(posedge clk);
      #2;
      r = '0;
      for (int i = 0; i < N; i++) begin
        if (bit_of(grant, i) && pend[i] > 0) pend[i]--;
        if (pend[i] > 0) r = r | (N'(1) << i);
      end
      req = r;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (grant != '0) begin
          for (int i = 0; i < N; i++) if (bit_of(grant, i)) gq.push_back(i);
          gcq.push_back(cyc);
        end
        if (tx_done) begin
          done_cnt++;
          dcq.push_back(cyc);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_busy = 1'b0; m_grant = '0; m_done = 1'b0;
        m_owner = 0; m_ptr = 0; m_ticks = 0; m_bits = '1;
      end else begin
        m_grant = '0;
        m_done  = 1'b0;
        if (!m_busy) begin
          if (req != '0) begin
            m_sel = -1;
            for (int k = 0; k < N; k++)
              if (m_sel < 0 && bit_of(req, (m_ptr + k) % N)) m_sel = (m_ptr + k) % N;
            m_grant = N'(1) << m_sel;
            m_owner = m_sel;
            m_ptr   = (m_sel + 1) % N;
            m_busy  = 1'b1;
            m_ticks = 0;
            m_byte  = 8'(req_data >> (m_sel * DW));
`ifdef UART_TX_PARITY_EN
            m_bits  = {2'b11, ^m_byte, m_byte, 1'b0};
`else
            m_bits  = {3'b111, m_byte, 1'b0};
`endif
          end
        end else if (baud_tick) begin
          m_ticks++;
          if (m_ticks == FB * OS) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("tx", 32'(tx), 32'(m_busy ? m_bits[4'(m_ticks / OS)] : 1'b1));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("tx_done", 32'(tx_done), 32'(m_done));
      chk("grant", 32'(grant), 32'(m_grant));
      if (m_busy) chk("owner", 32'(owner), m_owner);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    for (int i = 0; i < N; i++) pend[i] = 0;
    repeat (3) step();
    reset = 1'b0;
    gq.delete();
    gcq.delete();
    dcq.delete();
    done_cnt = 0;
    step();
  endtask

  task automatic wait_grant(input int budget, output logic [N-1:0] gv);
    gv = '0;
    for (int c = 0; c < budget && gv == '0; c++) begin
      @(negedge clk);
      gv = grant;
    end
    n_chk++;
    if (gv == '0) begin
      n_fail++;
      $display("FAIL wait_grant: no grant within %0d cycles", budget);
    end
  endtask

  task automatic wait_dones(input string name, input int n, input int budget);
    for (int c = 0; c < budget && done_cnt < n; c++) @(negedge clk);
    chk(name, done_cnt, n);
  endtask

  // Starts at the negedge where grant is visible; samples tx mid-bit and counts ticks to tx_done.
  task automatic frame_check(input string name, input logic [10:0] lit, input int lit_ticks);
    int cnt;
    bit fin;
    cnt = 0;
    fin = 1'b0;
    for (int c = 0; c < 2000 && !fin; c++) begin
      if (tx_done) fin = 1'b1;
      else begin
        if (baud_tick) begin
          cnt++;
          if (cnt % OS == 8 && cnt / OS < FB)
            chk({name, "_bit"}, 32'(tx), 32'(lit[4'(cnt / OS)]));
        end
        @(negedge clk);
      end
    end
    chk({name, "_fin"}, 32'(fin), 32'(1'b1));
    chk({name, "_ticks"}, cnt, lit_ticks);
  endtask

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    reset    = 1'b1;
    req_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'(1'b1));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_grant", 32'(grant), 32'(4'b0000));
    chk("rst_done", 32'(tx_done), 32'(1'b0));
    chk("rst_owner", 32'(owner), 32'(2'd0));
    step();
    reset = 1'b0;
    step();

    // Single request, 0x55
    req_data = {8'h00, 8'h00, 8'h00, 8'h55};
    pend[0] = 1;
    wait_grant(20, g);
    chk("t1_grant", 32'(g), 32'(4'b0001));
    frame_check("t1", LIT_55, LIT_TICKS);
    repeat (5) step();
    chk("t1_done_once", done_cnt, 1);

    // 0x07 frame (parity bit 1 when enabled)
    do_reset();
    req_data = {8'h00, 8'h00, 8'h00, 8'h07};
    pend[0] = 1;
    wait_grant(20, g);
    chk("t6_grant", 32'(g), 32'(4'b0001));
    frame_check("t6", LIT_07, LIT_TICKS);

    // All requests held
    do_reset();
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
    wait_dones("t2_done_count", 5, 2600);
    repeat (5) step();
    chk("t2_grant_count", gq.size(), 5);
    exp_o = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++)
      if (gq.size() > i) chk("t2_order", gq[i], exp_o[i]);

    // Pointer wrap
    do_reset();
    pend[3] = 1;
    wait_dones("t3_first_done", 1, 900);
    step();
    pend[0] = 1;
    pend[3] = 1;
    wait_dones("t3_done_count", 3, 1900);
    chk("t3_grant_count", gq.size(), 3);
    exp_o = '{3, 0, 3, 0, 0};
    for (int i = 0; i < 3; i++)
      if (gq.size() > i) chk("t3_order", gq[i], exp_o[i]);

    // Reset in the middle of data bit 4
    do_reset();
    req_data = {8'h00, 8'h00, 8'h3C, 8'h00};
    pend[1] = 1;
    wait_grant(20, g);
    chk("t4_grant", 32'(g), 32'(4'b0010));
    t_cnt = 0;
    for (int c = 0; c < 400 && t_cnt < 88; c++) begin
      if (baud_tick) t_cnt++;
      if (t_cnt < 88) @(negedge clk);
    end
    chk("t4_busy_before", 32'(busy), 32'(1'b1));
    step();
    reset = 1'b1;
    #1;
    chk("t4_rst_tx", 32'(tx), 32'(1'b1));
    chk("t4_rst_busy", 32'(busy), 32'(1'b0));
    repeat (2) step();
    reset = 1'b0;
    repeat (40) step();
    chk("t4_no_done", done_cnt, 0);
    req_data = {8'h00, 8'h5A, 8'h00, 8'h00};
    pend[2] = 1;
    wait_grant(20, g);
    chk("t4_regrant", 32'(g), 32'(4'b0100));
    wait_dones("t4_done", 1, 900);

    // Back-to-back from the same requester
    do_reset();
    req_data = {8'h00, 8'h00, 8'h81, 8'h00};
    pend[1] = 2;
    wait_dones("t5_done_count", 2, 1900);
    if (gcq.size() > 1 && dcq.size() > 0) chk("t5_b2b_gap", gcq[1] - dcq[0], 1);
    else chk("t5_b2b_seen", gcq.size(), 2);
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
